uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Sequences the UART receive path into the CPU's instruction and data memories.
- Pairs received bytes into 16-bit words (high byte first, then low byte) and writes each word to the memory chosen by UartSel at an auto-incrementing address.
- Holds the CPU stalled while a load is in progress.
- Sits between the UART receiver and the memory write ports inside the CPU/UART top level.

Parameters:
- AW, 8, memory address width for both instruction and data pointers.
- TIMEOUT_CYC, 250000, clk cycles allowed in WAIT_LO before the partial word is dropped. Default is about 2.4 byte frames at 9600 baud / 100 MHz.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- UartSel  input  2  load target: 0 idle, 1 instruction memory, 2 data memory, 3 reserved (treated as 0)
- rx_valid  input  1  one-cycle strobe from UART receiver: rx_data holds a completed byte
- rx_data  input  8  received byte
- rx_err  input  1  framing error, qualified by rx_valid
- ptr_clr  input  1  one-cycle pulse: clear both address pointers
- imem_we  output  1  instruction memory write enable (one-cycle pulse)
- dmem_we  output  1  data memory write enable (one-cycle pulse)
- load_addr  output  AW  write address for the active target
- load_data  output  16  write data {hi_byte, lo_byte}
- cpu_hold  output  1  stall request to the CPU
- word_drop  output  1  one-cycle pulse: partial word discarded
- ptr_wrap  output  1  one-cycle pulse: a pointer wrapped from 2^AW-1 to 0

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; hi_byte, lo_byte, iptr, dptr, timer and the latched target all 0.
  - All outputs 0.
  - Reset mid-word discards the word with no write and no word_drop.
- States:
  - IDLE: on UartSel in {1,2}, latch tgt=UartSel and go to WAIT_HI. UartSel 0 or 3 stays in IDLE.
  - WAIT_HI:
    - rx_valid && !rx_err: hi_byte<=rx_data, timer<=0, go to WAIT_LO.
    - rx_valid && rx_err: word_drop, go to IDLE.
    - UartSel!=tgt with no rx_valid: go to IDLE, no word_drop (nothing captured yet).
  - WAIT_LO:
    - rx_valid && !rx_err: lo_byte<=rx_data, go to WRITE.
    - rx_valid && rx_err: word_drop, go to IDLE.
    - UartSel!=tgt with no rx_valid: word_drop, go to IDLE.
    - timer reaches TIMEOUT_CYC-1: word_drop, go to IDLE.
    - Otherwise timer increments.
  - WRITE (exactly one cycle):
    - imem_we=1 if tgt==1, dmem_we=1 if tgt==2.
    - load_addr=pointer of tgt; load_data={hi_byte,lo_byte}.
    - Pointer of tgt increments at cycle end.
    - Next state: WAIT_HI if UartSel==tgt (streaming), else IDLE.
- Priority:
  - rx_valid in WAIT_HI/WAIT_LO beats a same-cycle UartSel change. The byte is accepted and the write still goes to the latched tgt.
  - Timeout and a same-cycle valid byte: the byte wins.
- Latency: the write pulse occurs in the cycle after the low-byte rx_valid is sampled.
- load_addr / load_data:
  - Registered and driven continuously.
  - Only meaningful while a write enable is high.
  - imem_we and dmem_we are never high together.
- Pointers:
  - iptr and dptr are independent and persist across UartSel returning to 0.
  - Cleared only by reset or ptr_clr.
  - Increment from 2^AW-1 wraps to 0 and pulses ptr_wrap in the same cycle as the write.
  - ptr_clr in the same cycle as WRITE: the write uses the old pointer, then the pointer becomes 0 (clear wins over increment).
- cpu_hold = (state!=IDLE) || (UartSel==1) || (UartSel==2). Combinational from state and UartSel, so it asserts in the same cycle UartSel goes active.

Test Plan:
- Reset release, UartSel=1, bytes 0x20 then 0xF2 -> one imem_we pulse one cycle after the 2nd rx_valid with load_addr=0, load_data=0x20F2; cpu_hold high from UartSel=1 until UartSel=0.
- Words 0x20F2, 0x1104, 0x0113, 0x0024 (sel=1, each followed by UartSel=0), then 0x0064, 0x00C8 (sel=2) -> imem addresses 0..3; dmem addresses 0,1 with data 0x0064, 0x00C8; no dmem_we during the imem phase.
- TIMEOUT_CYC=100, sel=2, byte 0x01 then no byte for 100 cycles -> word_drop pulse, no write; next full word 0x012C -> dmem_we at the unchanged dptr.
- sel=1, byte 0xAB, then UartSel->0 before the 2nd byte -> word_drop, no write, IDLE. Repeat with rx_valid in the same cycle as UartSel->0 -> imem_we occurs with the latched target.
- AW=2, sel=1 held high, five words streamed back-to-back -> addresses 0,1,2,3,0; ptr_wrap on the 4th write; rx_err on a 6th byte -> word_drop.
- reset low for one cycle while in WAIT_LO -> all outputs 0, pointers 0, no write; ptr_clr asserted with WRITE -> write at the old address, next word at address 0.

Source files
------------

// File: rtl/uart_mem_loader.sv
// UART-to-memory loader: pairs received bytes into 16-bit words and writes them
// to instruction or data memory at auto-incrementing addresses while the CPU is held.
module uart_mem_loader #(
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 250000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    UartSel,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_err,
    input  logic          ptr_clr,
    output logic          imem_we,
    output logic          dmem_we,
    output logic [AW-1:0] load_addr,
    output logic [15:0]   load_data,
    output logic          cpu_hold,
    output logic          word_drop,
    output logic          ptr_wrap
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    tgt;
    logic [7:0]    hi_byte;
    logic [AW-1:0] iptr;
    logic [AW-1:0] dptr;
    logic [TW-1:0] timer;
    logic          sel_active;
    logic          sel_changed;

    assign sel_active  = (UartSel == 2'd1) || (UartSel == 2'd2);
    assign sel_changed = (UartSel != tgt);

    // Combinational so the CPU stalls in the very cycle the host selects a target.
    assign cpu_hold = (state != IDLE) || sel_active;

    // The write strobes, address and data are registered on entry to WRITE, so the
    // pulse lands one cycle after the low byte; the low half of load_data is the low byte.
    // The target pointer advances on that same edge, and a ptr_clr applied later
    // in the sequence (including during WRITE) overrides it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tgt       <= 2'd0;
            hi_byte   <= 8'd0;
            iptr      <= '0;
            dptr      <= '0;
            timer     <= '0;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            load_addr <= '0;
            load_data <= 16'd0;
            word_drop <= 1'b0;
            ptr_wrap  <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            word_drop <= 1'b0;
            ptr_wrap  <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_active) begin
                        tgt   <= UartSel;
                        state <= WAIT_HI;
                    end
                end

                WAIT_HI: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            word_drop <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            hi_byte <= rx_data;
                            timer   <= '0;
                            state   <= WAIT_LO;
                        end
                    end else if (sel_changed) begin
                        state <= IDLE;
                    end
                end

                WAIT_LO: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            word_drop <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state     <= WRITE;
                            load_data <= {hi_byte, rx_data};
                            if (tgt == 2'd1) begin
                                imem_we   <= 1'b1;
                                load_addr <= iptr;
                                ptr_wrap  <= &iptr;
                                iptr      <= iptr + 1'b1;
                            end else begin
                                dmem_we   <= 1'b1;
                                load_addr <= dptr;
                                ptr_wrap  <= &dptr;
                                dptr      <= dptr + 1'b1;
                            end
                        end
                    end else if (sel_changed || (timer == TIMER_LAST)) begin
                        word_drop <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WRITE: begin
                    state <= (UartSel == tgt) ? WAIT_HI : IDLE;
                end

                default: state <= IDLE;
            endcase

            if (ptr_clr) begin
                iptr <= '0;
                dptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed scenarios plus randomized word
// traffic, checked against a transaction-level pointer/count model.
module tb_uart_mem_loader;

    localparam int AW    = 3;
    localparam int TO    = 40;
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic [1:0]    UartSel  = 2'd0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'd0;
    logic          rx_err   = 1'b0;
    logic          ptr_clr  = 1'b0;
    logic          imem_we;
    logic          dmem_we;
    logic [AW-1:0] load_addr;
    logic [15:0]   load_data;
    logic          cpu_hold;
    logic          word_drop;
    logic          ptr_wrap;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Observed pulse counts and the counts the model expects.
    int n_imem = 0, n_dmem = 0, n_drop = 0, n_wrap = 0, n_both = 0;
    int exp_imem = 0, exp_dmem = 0, exp_drop = 0, exp_wrap = 0;
    int iptr_m = 0, dptr_m = 0, cur_tgt = 0;

    uart_mem_loader #(.AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .UartSel(UartSel), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_err(rx_err), .ptr_clr(ptr_clr),
        .imem_we(imem_we), .dmem_we(dmem_we), .load_addr(load_addr),
        .load_data(load_data), .cpu_hold(cpu_hold), .word_drop(word_drop),
        .ptr_wrap(ptr_wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) n_imem++;
        if (dmem_we) n_dmem++;
        if (word_drop) n_drop++;
        if (ptr_wrap) n_wrap++;
        if (imem_we && dmem_we) n_both++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e);
        rx_valid = v;
        rx_data  = d;
        rx_err   = e;
    endtask

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_we"}, {imem_we, dmem_we}, 32'd0);
        checkOutput({tag, "_addr"}, 32'(load_addr), 32'd0);
        checkOutput({tag, "_data"}, 32'(load_data), 32'd0);
        checkOutput({tag, "_drop"}, 32'(word_drop), 32'd0);
        checkOutput({tag, "_wrap"}, 32'(ptr_wrap), 32'd0);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    // Select a target from IDLE; hold must rise combinationally before the edge.
    task automatic start_target(input int s);
        UartSel = 2'(s);
        #1;
        checkOutput("hold_on_sel", 32'(cpu_hold), 32'((s == 1) || (s == 2)));
        cur_tgt = s;
        tick();
    endtask

    task automatic go_idle();
        UartSel = 2'd0;
        tick();
        checkOutput("idle_hold", 32'(cpu_hold), 32'd0);
        checkOutput("idle_nodrop", 32'(word_drop), 32'd0);
    endtask

    // err_kind: 0 clean word, 1 framing error on high byte, 2 on low byte.
    task automatic send_word(input logic [15:0] w, input int gap, input int err_kind, input bit clr);
        int ea;
        applyStimulus(1'b1, w[15:8], err_kind == 1);
        tick();
        applyStimulus(1'b0, 8'($urandom), 1'b0);
        if (err_kind == 1) begin
            checkOutput("drop_hi_err", 32'(word_drop), 32'd1);
            checkOutput("nowr_hi_err", {imem_we, dmem_we}, 32'd0);
            exp_drop++;
            tick();
            return;
        end
        for (int i = 0; i < gap; i++) tick();
        applyStimulus(1'b1, w[7:0], err_kind == 2);
        tick();
        applyStimulus(1'b0, 8'($urandom), 1'b0);
        if (err_kind == 2) begin
            checkOutput("drop_lo_err", 32'(word_drop), 32'd1);
            checkOutput("nowr_lo_err", {imem_we, dmem_we}, 32'd0);
            exp_drop++;
            tick();
            return;
        end
        ptr_clr = clr;
        ea = (cur_tgt == 1) ? iptr_m : dptr_m;
        checkOutput("imem_we", 32'(imem_we), 32'(cur_tgt == 1));
        checkOutput("dmem_we", 32'(dmem_we), 32'(cur_tgt == 2));
        checkOutput("load_addr", 32'(load_addr), 32'(ea));
        checkOutput("load_data", 32'(load_data), 32'(w));
        checkOutput("ptr_wrap", 32'(ptr_wrap), 32'(ea == DEPTH - 1));
        checkOutput("hold_in_write", 32'(cpu_hold), 32'd1);
        if (cur_tgt == 1) begin
            exp_imem++;
            iptr_m = (iptr_m + 1) % DEPTH;
        end else begin
            exp_dmem++;
            dptr_m = (dptr_m + 1) % DEPTH;
        end
        if (ea == DEPTH - 1) exp_wrap++;
        if (clr) begin
            iptr_m = 0;
            dptr_m = 0;
        end
        tick();
        ptr_clr = 1'b0;
        checkOutput("we_single_pulse", {imem_we, dmem_we}, 32'd0);
    endtask

    task automatic check_counts(input string tag);
        checkOutput({tag, "_imem_cnt"}, 32'(n_imem), 32'(exp_imem));
        checkOutput({tag, "_dmem_cnt"}, 32'(n_dmem), 32'(exp_dmem));
        checkOutput({tag, "_drop_cnt"}, 32'(n_drop), 32'(exp_drop));
        checkOutput({tag, "_wrap_cnt"}, 32'(n_wrap), 32'(exp_wrap));
        checkOutput({tag, "_both_cnt"}, 32'(n_both), 32'd0);
    endtask

    initial begin
        logic [15:0] wd;
        int s, ek, gp;
        bit cl;

        // Reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b1;
        tick();

        // First word into instruction memory, then imem/dmem load phases
        start_target(1);
        send_word(16'h20F2, 3, 0, 1'b0);
        checkOutput("hold_while_sel", 32'(cpu_hold), 32'd1);
        go_idle();
        start_target(1); send_word(16'h1104, 0, 0, 1'b0); go_idle();
        start_target(1); send_word(16'h0113, 5, 0, 1'b0); go_idle();
        start_target(1); send_word(16'h0024, 1, 0, 1'b0); go_idle();
        check_counts("imem_phase");
        start_target(2); send_word(16'h0064, 2, 0, 1'b0); go_idle();
        start_target(2); send_word(16'h00C8, 0, 0, 1'b0); go_idle();
        check_counts("dmem_phase");

        // Timeout: high byte only, drop exactly TO edges later
        start_target(2);
        applyStimulus(1'b1, 8'h01, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (TO - 1) tick();
        checkOutput("no_drop_before_timeout", 32'(word_drop), 32'd0);
        tick();
        checkOutput("timeout_drop", 32'(word_drop), 32'd1);
        checkOutput("timeout_nowr", {imem_we, dmem_we}, 32'd0);
        exp_drop++;
        tick();
        send_word(16'h012C, 0, 0, 1'b0);
        send_word(16'h0BEE, TO - 1, 0, 1'b0);
        go_idle();

        // Target deselected between bytes
        start_target(1);
        applyStimulus(1'b1, 8'hAB, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        UartSel = 2'd0;
        #1;
        checkOutput("hold_wait_lo", 32'(cpu_hold), 32'd1);
        tick();
        checkOutput("desel_drop", 32'(word_drop), 32'd1);
        checkOutput("desel_nowr", {imem_we, dmem_we}, 32'd0);
        checkOutput("desel_idle_hold", 32'(cpu_hold), 32'd0);
        exp_drop++;
        tick();

        // Low byte in the same cycle as deselect still writes the latched target
        start_target(1);
        applyStimulus(1'b1, 8'h55, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h66, 1'b0);
        UartSel = 2'd0;
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("race_imem_we", 32'(imem_we), 32'd1);
        checkOutput("race_addr", 32'(load_addr), 32'(iptr_m));
        checkOutput("race_data", 32'(load_data), 32'h5566);
        exp_imem++;
        if (iptr_m == DEPTH - 1) exp_wrap++;
        iptr_m = (iptr_m + 1) % DEPTH;
        tick();
        checkOutput("race_idle_hold", 32'(cpu_hold), 32'd0);

        // Reserved selector behaves as idle
        UartSel = 2'd3;
        #1;
        checkOutput("sel3_hold", 32'(cpu_hold), 32'd0);
        tick();
        applyStimulus(1'b1, 8'h12, 1'b0); tick();
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        applyStimulus(1'b1, 8'h34, 1'b0); tick();
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("sel3_hold_after", 32'(cpu_hold), 32'd0);
        UartSel = 2'd0;
        tick();
        check_counts("sel3");

        // Streaming with wrap, then a framing error
        start_target(1);
        for (int i = 0; i < 10; i++) send_word(16'($urandom), 0, 0, 1'b0);
        send_word(16'hDEAD, 0, 1, 1'b0);
        go_idle();
        check_counts("stream");

        // Reset in WAIT_LO discards the word silently
        start_target(2);
        applyStimulus(1'b1, 8'h77, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        reset   = 1'b0;
        UartSel = 2'd0;
        tick();
        check_idle_outputs("mid_reset");
        reset  = 1'b1;
        iptr_m = 0;
        dptr_m = 0;
        tick();
        check_counts("after_reset");
        start_target(1); send_word(16'hA1A2, 1, 0, 1'b0); go_idle();
        start_target(2); send_word(16'hB1B2, 1, 0, 1'b0);

        // ptr_clr during WRITE: old address used, both pointers then zero
        send_word(16'hC1C2, 0, 0, 1'b1);
        send_word(16'hD1D2, 0, 0, 1'b0);
        go_idle();
        start_target(1); send_word(16'hE1E2, 0, 0, 1'b0); go_idle();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            s  = int'($urandom_range(1, 2));
            wd = 16'($urandom);
            gp = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 5));
            ek = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            cl = (ek == 0) && ($urandom_range(0, 11) == 0);
            start_target(s);
            send_word(wd, gp, ek, cl);
            if ($urandom_range(0, 1) == 1) send_word(16'($urandom), 0, 0, 1'b0);
            go_idle();
        end
        check_counts("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
